// File: rtl/lsq_param_if.sv
// rtl/lsq_param_if.sv - dispatch, memory and broadcast bundle for lsq_param
interface lsq_param_if #(
    parameter int ROB_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_store;
    logic [2:0]       in_size;
    logic [ROB_W-1:0] in_tag;
    logic [31:0]      in_rs1_val;
    logic [31:0]      in_rs2_val;
    logic [31:0]      in_imm;
    logic             in_rs1_wait;
    logic             in_rs2_wait;
    logic [ROB_W-1:0] in_rs1_tag;
    logic [ROB_W-1:0] in_rs2_tag;

    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [2:0]       mem_size;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    logic             bc_valid;
    logic [ROB_W-1:0] bc_tag;
    logic [31:0]      bc_value;

    // Environment side: dispatch and memory controller
    modport master (
        output in_valid, in_store, in_size, in_tag, in_rs1_val, in_rs2_val, in_imm,
        output in_rs1_wait, in_rs2_wait, in_rs1_tag, in_rs2_tag,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output mem_ack, mem_rdata,
        input  bc_valid, bc_tag, bc_value
    );

    // Queue side
    modport slave (
        input  in_valid, in_store, in_size, in_tag, in_rs1_val, in_rs2_val, in_imm,
        input  in_rs1_wait, in_rs2_wait, in_rs1_tag, in_rs2_tag,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  mem_ack, mem_rdata,
        output bc_valid, bc_tag, bc_value
    );
endinterface

// File: rtl/lsq_param.sv
// rtl/lsq_param.sv - parametrised in-order load/store queue; optional LSQ_IO_GUARD_EN holds I/O loads until commit
module lsq_param #(
    parameter int          DEPTH   = 16,
    parameter int          ROB_W   = 4,
    parameter int          CDB_N   = 2,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    lsq_param_if.slave             bus,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*ROB_W-1:0] cdb_tag,
    input  logic [CDB_N*32-1:0]    cdb_value,
    input  logic                   commit_valid,
    input  logic [ROB_W-1:0]       commit_tag
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } cap_t;

    // Lowest channel index wins when several channels carry the same tag.
    function automatic cap_t cdb_match(
        input logic [ROB_W-1:0]       t,
        input logic [CDB_N-1:0]       v,
        input logic [CDB_N*ROB_W-1:0] tg,
        input logic [CDB_N*32-1:0]    val
    );
        cap_t r;
        r = '0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (v[c] && tg[c*ROB_W +: ROB_W] == t) begin
                r.hit = 1'b1;
                r.val = val[c*32 +: 32];
            end
        end
        return r;
    endfunction

    // Entry storage
    logic             e_store     [DEPTH];
    logic [2:0]       e_size      [DEPTH];
    logic [ROB_W-1:0] e_tag       [DEPTH];
    logic [31:0]      e_base      [DEPTH];
    logic             e_base_wait [DEPTH];
    logic [ROB_W-1:0] e_base_tag  [DEPTH];
    logic [31:0]      e_data      [DEPTH];
    logic             e_data_wait [DEPTH];
    logic [ROB_W-1:0] e_data_tag  [DEPTH];
    logic [31:0]      e_imm       [DEPTH];
    logic             e_comm      [DEPTH];

    // Queue bookkeeping; ccount_q is the distance from head to one past the
    // youngest entry that survives a flush (the committed-store boundary).
    logic [PTR_W-1:0] head_q, tail_q, head_n, tail_n;
    logic [CNT_W-1:0] count_q, count_n, ccount_q, ccount_n, ccount_p, ccount_c;
    logic             drop_q, drop_n;
    state_t           state_q, state_n;

    logic             mem_req_q, mem_req_n, mem_we_q, mem_we_n;
    logic [31:0]      mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
    logic [2:0]       mem_size_q, mem_size_n;
    logic             bc_valid_q, bc_valid_n;
    logic [ROB_W-1:0] bc_tag_q, bc_tag_n;
    logic [31:0]      bc_value_q, bc_value_n;

    logic [DEPTH-1:0] live;
    logic             c_hit, c_bound;
    logic [PTR_W-1:0] c_idx;
    logic [CNT_W-1:0] c_dist;
    logic             in_ready, accept, pop, head_kept;
    logic             h_store, h_is_io, h_load_ok, h_elig;
    logic [31:0]      h_addr;
    cap_t             base_cap [DEPTH];
    cap_t             data_cap [DEPTH];
    cap_t             rs1_cap, rs2_cap;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign accept    = bus.in_valid && in_ready && !flush;
    assign pop       = (state_q == S_WAIT) && bus.mem_ack;
    assign head_kept = (ccount_q != '0);

    assign bus.in_ready  = in_ready;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.bc_valid  = bc_valid_q;
    assign bus.bc_tag    = bc_tag_q;
    assign bus.bc_value  = bc_value_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_live
        assign live[g] = ({1'b0, PTR_W'(g) - head_q} < count_q);
    end

    // CDB snoop for every stored operand and for the operands being dispatched
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            base_cap[i] = cdb_match(e_base_tag[i], cdb_valid, cdb_tag, cdb_value);
            data_cap[i] = cdb_match(e_data_tag[i], cdb_valid, cdb_tag, cdb_value);
        end
        rs1_cap = cdb_match(bus.in_rs1_tag, cdb_valid, cdb_tag, cdb_value);
        rs2_cap = cdb_match(bus.in_rs2_tag, cdb_valid, cdb_tag, cdb_value);
    end

    // Locate the live entry named by the commit tag
    always_comb begin
        c_hit = 1'b0;
        c_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!c_hit && commit_valid && live[i] && e_tag[i] == commit_tag) begin
                c_hit = 1'b1;
                c_idx = PTR_W'(i);
            end
        end
        c_dist = {1'b0, c_idx - head_q} + CNT_W'(1);
    end

    assign h_store = e_store[head_q];
    assign h_addr  = e_base[head_q] + e_imm[head_q];
    assign h_is_io = (h_addr >= IO_BASE);

`ifdef LSQ_IO_GUARD_EN
    // A committed I/O load must survive a flush, so any commit moves the boundary.
    assign c_bound   = c_hit;
    assign h_load_ok = !h_is_io || e_comm[head_q];
`else
    logic unused_io;
    assign unused_io = h_is_io;
    assign c_bound   = c_hit && e_store[c_idx];
    assign h_load_ok = 1'b1;
`endif

    assign h_elig = (count_q != '0) && !e_base_wait[head_q] &&
                    (h_store ? (!e_data_wait[head_q] && e_comm[head_q]) : h_load_ok);

    // Next head/tail/count/boundary, including flush truncation
    always_comb begin
        ccount_p = ccount_q - CNT_W'(pop && head_kept);
        ccount_c = ccount_p;
        if (c_bound && (c_dist - CNT_W'(pop)) > ccount_p) begin
            ccount_c = c_dist - CNT_W'(pop);
        end
        head_n   = head_q + PTR_W'(pop);
        tail_n   = tail_q + PTR_W'(accept);
        count_n  = count_q + CNT_W'(accept) - CNT_W'(pop);
        ccount_n = ccount_c;
        drop_n   = pop ? 1'b0 : drop_q;
        if (flush) begin
            if (state_q == S_WAIT && !pop && !head_kept) begin
                // Discarded load still owns the bus: keep its slot until the ack.
                count_n  = CNT_W'(1);
                tail_n   = head_q + PTR_W'(1);
                ccount_n = '0;
                drop_n   = 1'b1;
            end else begin
                count_n  = ccount_p;
                tail_n   = head_n + ccount_p[PTR_W-1:0];
                ccount_n = ccount_p;
            end
        end
    end

    // Issue FSM: request the head entry, wait for its single-cycle ack
    always_comb begin
        state_n     = state_q;
        mem_req_n   = mem_req_q;
        mem_we_n    = mem_we_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        mem_size_n  = mem_size_q;
        bc_valid_n  = 1'b0;
        bc_tag_n    = bc_tag_q;
        bc_value_n  = bc_value_q;
        case (state_q)
            S_IDLE: begin
                if (h_elig && !(flush && !head_kept)) begin
                    state_n     = S_WAIT;
                    mem_req_n   = 1'b1;
                    mem_we_n    = h_store;
                    mem_addr_n  = h_addr;
                    mem_wdata_n = e_data[head_q];
                    mem_size_n  = e_size[head_q];
                end
            end
            S_WAIT: begin
                if (bus.mem_ack) begin
                    state_n   = S_IDLE;
                    mem_req_n = 1'b0;
                    if (!h_store && !drop_q && !(flush && !head_kept)) begin
                        bc_valid_n = 1'b1;
                        bc_tag_n   = e_tag[head_q];
                        bc_value_n = bus.mem_rdata;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ccount_q    <= '0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            bc_valid_q  <= 1'b0;
            bc_tag_q    <= '0;
            bc_value_q  <= '0;
        end else if (rdy) begin
            state_q     <= state_n;
            head_q      <= head_n;
            tail_q      <= tail_n;
            count_q     <= count_n;
            ccount_q    <= ccount_n;
            drop_q      <= drop_n;
            mem_req_q   <= mem_req_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            mem_size_q  <= mem_size_n;
            bc_valid_q  <= bc_valid_n;
            bc_tag_q    <= bc_tag_n;
            bc_value_q  <= bc_value_n;
        end
    end

    // Entry array: operand capture, commit marks, dispatch write at tail
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_base_wait[i] && base_cap[i].hit) begin
                    e_base[i]      <= base_cap[i].val;
                    e_base_wait[i] <= 1'b0;
                end
                if (e_data_wait[i] && data_cap[i].hit) begin
                    e_data[i]      <= data_cap[i].val;
                    e_data_wait[i] <= 1'b0;
                end
                if (!flush && c_hit && c_idx == PTR_W'(i)) begin
                    e_comm[i] <= 1'b1;
                end
            end
            if (accept) begin
                e_store[tail_q]     <= bus.in_store;
                e_size[tail_q]      <= bus.in_size;
                e_tag[tail_q]       <= bus.in_tag;
                e_imm[tail_q]       <= bus.in_imm;
                e_comm[tail_q]      <= 1'b0;
                e_base[tail_q]      <= (bus.in_rs1_wait && rs1_cap.hit) ? rs1_cap.val : bus.in_rs1_val;
                e_base_wait[tail_q] <= bus.in_rs1_wait && !rs1_cap.hit;
                e_base_tag[tail_q]  <= bus.in_rs1_tag;
                e_data[tail_q]      <= (bus.in_rs2_wait && rs2_cap.hit) ? rs2_cap.val : bus.in_rs2_val;
                e_data_wait[tail_q] <= bus.in_rs2_wait && !rs2_cap.hit;
                e_data_tag[tail_q]  <= bus.in_rs2_tag;
            end
        end
    end
endmodule

// File: tb/tb_lsq_param.sv
// tb/tb_lsq_param.sv - directed self-checking bench for lsq_param
module tb_lsq_param;
    localparam int DEPTH = 16;
    localparam int ROB_W = 4;
    localparam int CDB_N = 2;

    logic                   clk = 1'b0;
    logic                   rst, rdy, flush;
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*ROB_W-1:0] cdb_tag;
    logic [CDB_N*32-1:0]    cdb_value;
    logic                   commit_valid;
    logic [ROB_W-1:0]       commit_tag;

    int n_tests = 0;
    int n_fail  = 0;

    lsq_param_if #(.ROB_W(ROB_W)) bus ();

    lsq_param #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .CDB_N(CDB_N), .IO_BASE(32'h0003_0000)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      base;
        logic [31:0]      imm;
        logic [ROB_W-1:0] tag;
        logic [2:0]       size;
        logic [31:0]      rdata;
        logic [31:0]      exp_addr;
    } ld_vec_t;

    ld_vec_t vec [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [2:0] sz, input logic [ROB_W-1:0] tg,
                        input logic [31:0] b, input logic [31:0] im, input logic [31:0] d,
                        input logic w1, input logic [ROB_W-1:0] t1,
                        input logic w2, input logic [ROB_W-1:0] t2);
        bus.in_valid    = 1'b1;
        bus.in_store    = st;
        bus.in_size     = sz;
        bus.in_tag      = tg;
        bus.in_rs1_val  = b;
        bus.in_imm      = im;
        bus.in_rs2_val  = d;
        bus.in_rs1_wait = w1;
        bus.in_rs1_tag  = t1;
        bus.in_rs2_wait = w2;
        bus.in_rs2_tag  = t2;
        step();
        bus.in_valid    = 1'b0;
        bus.in_rs1_wait = 1'b0;
        bus.in_rs2_wait = 1'b0;
    endtask

    task automatic commit_t(input logic [ROB_W-1:0] t);
        commit_valid = 1'b1;
        commit_tag   = t;
        step();
        commit_valid = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({nm, "_req_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic no_req(input string nm, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.mem_req !== 1'b0) hits++;
        end
        chk(nm, hits, 0);
    endtask

    task automatic ack(input logic [31:0] d);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        step();
        bus.mem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{32'h0000_0100, 32'h0000_0004, 4'd1, 3'b010, 32'hDEAD_BEEF, 32'h0000_0104};
        vec[1] = '{32'hFFFF_FFFC, 32'h0000_0008, 4'd2, 3'b100, 32'h1234_5678, 32'h0000_0004};
        vec[2] = '{32'h0000_2000, 32'hFFFF_FFF0, 4'd3, 3'b001, 32'h0000_00A5, 32'h0000_1FF0};
        vec[3] = '{32'h0000_0000, 32'h0000_0000, 4'd4, 3'b000, 32'hFFFF_FFFF, 32'h0000_0000};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        commit_valid = 1'b0; commit_tag = '0;
        bus.in_valid = 1'b0; bus.in_store = 1'b0; bus.in_size = '0; bus.in_tag = '0;
        bus.in_rs1_val = '0; bus.in_rs2_val = '0; bus.in_imm = '0;
        bus.in_rs1_wait = 1'b0; bus.in_rs2_wait = 1'b0; bus.in_rs1_tag = '0; bus.in_rs2_tag = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        step(); step(); step();

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_size", 32'(bus.mem_size), 32'd0);
        chk("rst_bc_valid", 32'(bus.bc_valid), 32'd0);
        chk("rst_bc_tag", 32'(bus.bc_tag), 32'd0);
        chk("rst_bc_value", bus.bc_value, 32'd0);
        rst = 1'b0;
        step();

        // Table-driven single loads: request timing, address arithmetic, broadcast
        for (int v = 0; v < 4; v++) begin
            push(1'b0, vec[v].size, vec[v].tag, vec[v].base, vec[v].imm, 32'd0, 1'b0, '0, 1'b0, '0);
            chk("ld_no_req_at_accept", 32'(bus.mem_req), 32'd0);
            step();
            chk("ld_req_1cyc", 32'(bus.mem_req), 32'd1);
            chk("ld_addr", bus.mem_addr, vec[v].exp_addr);
            chk("ld_we", 32'(bus.mem_we), 32'd0);
            chk("ld_size", 32'(bus.mem_size), 32'(vec[v].size));
            ack(vec[v].rdata);
            chk("ld_req_drop", 32'(bus.mem_req), 32'd0);
            chk("ld_bc_valid", 32'(bus.bc_valid), 32'd1);
            chk("ld_bc_tag", 32'(bus.bc_tag), 32'(vec[v].tag));
            chk("ld_bc_value", bus.bc_value, vec[v].rdata);
            step();
            chk("ld_bc_pulse", 32'(bus.bc_valid), 32'd0);
        end

        // Store: data captured from CDB ch1 at accept, held until commit
        cdb_valid = 2'b10;
        cdb_tag   = {4'd3, 4'd9};
        cdb_value = {32'h0000_0055, 32'h0000_0099};
        push(1'b1, 3'b010, 4'd5, 32'h0000_0200, 32'd0, 32'd0, 1'b0, '0, 1'b1, 4'd3);
        cdb_valid = '0;
        no_req("st_no_req_before_commit", 5);
        commit_t(4'd5);
        chk("st_no_req_at_commit", 32'(bus.mem_req), 32'd0);
        step();
        chk("st_req_after_commit", 32'(bus.mem_req), 32'd1);
        chk("st_we", 32'(bus.mem_we), 32'd1);
        chk("st_wdata", bus.mem_wdata, 32'h0000_0055);
        chk("st_addr", bus.mem_addr, 32'h0000_0200);
        ack(32'hFFFF_0000);
        chk("st_no_bc", 32'(bus.bc_valid), 32'd0);

        // Load base waiting on tag 7; both channels broadcast it, ch0 must win
        push(1'b0, 3'b010, 4'd6, 32'd0, 32'h0000_0010, 32'd0, 1'b1, 4'd7, 1'b0, '0);
        no_req("prio_no_req_while_wait", 3);
        cdb_valid = 2'b11;
        cdb_tag   = {4'd7, 4'd7};
        cdb_value = {32'h0000_2000, 32'h0000_1000};
        step();
        cdb_valid = '0;
        wait_req("prio");
        chk("prio_addr", bus.mem_addr, 32'h0000_1010);
        ack(32'h0000_0042);
        chk("prio_bc_value", bus.bc_value, 32'h0000_0042);

        // Fill: DEPTH uncommitted stores, extra offer rejected, slot frees after pop
        for (int i = 0; i < DEPTH; i++) begin
            push(1'b1, 3'b010, ROB_W'(i), 32'h0000_1000 + 32'(4 * i), 32'd0, 32'(i),
                 1'b0, '0, 1'b0, '0);
            if (i == DEPTH - 2) chk("fill_ready_before_full", 32'(bus.in_ready), 32'd1);
        end
        chk("fill_full_ready", 32'(bus.in_ready), 32'd0);
        push(1'b1, 3'b010, 4'd0, 32'h0000_BAD0, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        chk("fill_extra_ready", 32'(bus.in_ready), 32'd0);
        commit_t(4'd0);
        wait_req("fill_first");
        chk("fill_first_addr", bus.mem_addr, 32'h0000_1000);
        chk("fill_ready_at_ack", 32'(bus.in_ready), 32'd0);
        ack(32'd0);
        chk("fill_ready_after_pop", 32'(bus.in_ready), 32'd1);
        for (int i = 1; i < DEPTH; i++) commit_t(ROB_W'(i));
        for (int i = 1; i < DEPTH; i++) begin
            wait_req("fill_drain");
            chk("fill_drain_addr", bus.mem_addr, 32'h0000_1000 + 32'(4 * i));
            chk("fill_drain_wdata", bus.mem_wdata, 32'(i));
            ack(32'd0);
        end
        no_req("fill_extra_not_accepted", 6);

        // Pointer wrap: 3*DEPTH loads in batches of four, FIFO order kept
        for (int b = 0; b < (3 * DEPTH) / 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                push(1'b0, 3'b010, ROB_W'(b * 4 + k), 32'h0000_4000 + 32'(4 * (b * 4 + k)),
                     32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
            end
            for (int k = 0; k < 4; k++) begin
                wait_req("wrap");
                chk("wrap_addr", bus.mem_addr, 32'h0000_4000 + 32'(4 * (b * 4 + k)));
                ack(32'h0000_A000 + 32'(b * 4 + k));
                chk("wrap_bc_value", bus.bc_value, 32'h0000_A000 + 32'(b * 4 + k));
            end
        end

        // Flush while committed store S is in flight; younger loads and the
        // flush-cycle dispatch are discarded
        push(1'b1, 3'b010, 4'd1, 32'h0000_0500, 32'd0, 32'h0000_CAFE, 1'b0, '0, 1'b0, '0);
        push(1'b0, 3'b010, 4'd2, 32'h0000_0600, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        push(1'b0, 3'b010, 4'd3, 32'h0000_0604, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        commit_t(4'd1);
        wait_req("fl_store");
        chk("fl_store_addr", bus.mem_addr, 32'h0000_0500);
        flush = 1'b1;
        push(1'b0, 3'b010, 4'd7, 32'h0000_0F00, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        flush = 1'b0;
        chk("fl_store_req_held", 32'(bus.mem_req), 32'd1);
        chk("fl_store_addr_held", bus.mem_addr, 32'h0000_0500);
        chk("fl_store_we", 32'(bus.mem_we), 32'd1);
        chk("fl_store_wdata", bus.mem_wdata, 32'h0000_CAFE);
        ack(32'd0);
        chk("fl_store_no_bc", 32'(bus.bc_valid), 32'd0);
        no_req("fl_younger_discarded", 6);

        // Flush while a load is in flight, ack later: no broadcast
        push(1'b0, 3'b010, 4'd4, 32'h0000_0700, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        wait_req("fl_ld");
        chk("fl_ld_addr", bus.mem_addr, 32'h0000_0700);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_ld_req_held", 32'(bus.mem_req), 32'd1);
        ack(32'h0000_1234);
        chk("fl_ld_no_bc", 32'(bus.bc_valid), 32'd0);
        no_req("fl_ld_empty", 4);

        // Flush and ack in the same cycle: no broadcast
        push(1'b0, 3'b010, 4'd5, 32'h0000_0704, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        wait_req("fl_ack");
        flush         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_5678;
        step();
        flush       = 1'b0;
        bus.mem_ack = 1'b0;
        chk("fl_ack_no_bc", 32'(bus.bc_valid), 32'd0);
        no_req("fl_ack_empty", 3);

        // Queue drained: a fresh load goes straight out
        push(1'b0, 3'b010, 4'd6, 32'h0000_0800, 32'd0, 32'd0, 1'b0, '0, 1'b0, '0);
        step();
        chk("post_fl_req", 32'(bus.mem_req), 32'd1);
        chk("post_fl_addr", bus.mem_addr, 32'h0000_0800);
        ack(32'h0000_0077);
        chk("post_fl_bc_valid", 32'(bus.bc_valid), 32'd1);
        chk("post_fl_bc_tag", 32'(bus.bc_tag), 32'd6);
        chk("post_fl_bc_value", bus.bc_value, 32'h0000_0077);

        // I/O-region load
        push(1'b0, 3'b010, 4'd8, 32'h0003_0000, 32'h0000_0004, 32'd0, 1'b0, '0, 1'b0, '0);
`ifdef LSQ_IO_GUARD_EN
        no_req("io_held_uncommitted", 5);
        commit_t(4'd8);
        chk("io_no_req_at_commit", 32'(bus.mem_req), 32'd0);
        step();
`else
        step();
`endif
        chk("io_req", 32'(bus.mem_req), 32'd1);
        chk("io_addr", bus.mem_addr, 32'h0003_0004);
        ack(32'h0000_0ABC);
        chk("io_bc_valid", 32'(bus.bc_valid), 32'd1);
        chk("io_bc_value", bus.bc_value, 32'h0000_0ABC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
